// File: rtl/shiftreg_out_bank_if.sv
// Drain stream between the output register bank and the downstream writer.
// The bank drives data/valid/last; the writer answers with ready.
interface shiftreg_out_bank_if #(
    parameter int B = 24
) ();
    logic [B-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;

    modport master (output dout, output dout_valid, output dout_last, input dout_ready);
    modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/shiftreg_out_bank.sv
// Output register bank for the perceptron lanes: capture, shift, two registered read ports, drain FSM.
// Define OUTBANK_ROTATE_EN to make shift_en rotate the bank instead of shifting in shift_in.
module shiftreg_out_bank #(
    parameter int B  = 24,
    parameter int N  = 40,
    parameter int AW = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*B-1:0]        ins,
    input  logic                  ins_vld,
    input  logic [B-1:0]          shift_in,
    input  logic                  shift_en,
    input  logic                  drain_start,
    shiftreg_out_bank_if.master   drn,
    output logic                  busy,
    output logic [N*B-1:0]        outs,
    input  logic [AW-1:0]         addr1,
    output logic [B-1:0]          out1,
    input  logic [AW-1:0]         addr2,
    output logic [B-1:0]          out2
);

    typedef enum logic [0:0] {IDLE, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [N-1:0][B-1:0]   lanes_q, lanes_d;
    logic [N-1:0][B-1:0]   ins_lanes;
    logic [B-1:0]          out1_q, out1_d;
    logic [B-1:0]          out2_q, out2_d;
    logic                  last_word;

    // Addresses at or beyond N match no lane and read back as zero.
    function automatic logic [B-1:0] pick(input logic [N-1:0][B-1:0] bank,
                                          input logic [AW-1:0] a);
        pick = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(a) == i) pick = bank[i];
        end
    endfunction

    assign ins_lanes = ins;
    assign last_word = (state_q == DRAIN) && (int'(cnt_q) == N - 1);

`ifdef OUTBANK_ROTATE_EN
    logic unused_shift_in;
    assign unused_shift_in = ^shift_in;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        case (state_q)
            IDLE: begin
                if (ins_vld) begin
                    lanes_d = ins_lanes;
                end else if (shift_en) begin
                    for (int i = N - 1; i > 0; i--) lanes_d[i] = lanes_q[i-1];
`ifdef OUTBANK_ROTATE_EN
                    lanes_d[0] = lanes_q[N-1];
`else
                    lanes_d[0] = shift_in;
`endif
                end
                if (drain_start) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (drn.dout_ready) begin
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read ports sample the bank as it stands before this edge's update.
    always_comb begin
        out1_d = pick(lanes_q, addr1);
        out2_d = pick(lanes_q, addr2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lanes_q <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
        end
    end

    assign drn.dout       = (state_q == DRAIN) ? pick(lanes_q, cnt_q) : '0;
    assign drn.dout_valid = (state_q == DRAIN);
    assign drn.dout_last  = last_word;
    assign busy           = (state_q == DRAIN);
    assign outs           = lanes_q;
    assign out1           = out1_q;
    assign out2           = out2_q;

endmodule
